// File: rtl/core_axil_io_master_if.sv
// core_axil_io_master_if: core request/response port plus the AXI4-Lite master channels.
interface core_axil_io_master_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    localparam int SW = DATA_W / 8;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [SW-1:0]     req_wstrb;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_resp;
    logic              rsp_timeout;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [SW-1:0]     wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
               arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid,
        output req_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
               araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready
    );
    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
               arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid,
        input  req_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
               araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready
    );
endinterface

// File: rtl/core_axil_io_master.sv
// core_axil_io_master: single-outstanding AXI4-Lite master for core I/O with timeout abort.
module core_axil_io_master #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic rst,
    core_axil_io_master_if.master bus
);
    localparam int SW = DATA_W / 8;
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B, RESP} state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_rdata, w_rdata;
    logic [SW-1:0]     r_wstrb;
    logic [1:0]        r_resp, w_resp;
    logic [CW-1:0]     r_cnt;
    logic              r_tout, r_aw_done, r_w_done;
    logic              w_busy, w_expire, w_aw_ok, w_w_ok, w_cap, w_tout;

    assign w_busy   = r_state != IDLE && r_state != RESP;
    assign w_expire = TIMEOUT != 0 && w_busy && r_cnt == CW'(TIMEOUT);
    assign w_aw_ok  = r_aw_done | bus.awready;
    assign w_w_ok   = r_w_done | bus.wready;

    always_comb begin
        w_next = r_state;
        w_tout = 1'b0;
        case (r_state)
            IDLE:    w_next = bus.req_valid ? (bus.req_we ? WR_AW : RD_A) : IDLE;
            RD_A:    w_next = bus.arready ? RD_D : RD_A;
            RD_D:    w_next = bus.rvalid ? RESP : RD_D;
            WR_AW:   w_next = (w_aw_ok && w_w_ok) ? WR_B : WR_AW;
            WR_B:    w_next = bus.bvalid ? RESP : WR_B;
            default: w_next = IDLE;
        endcase
        // only the final R/B handshake beats an expiring counter
        if (w_expire && w_next != RESP) begin
            w_next = RESP;
            w_tout = 1'b1;
        end
        w_cap   = w_busy && w_next == RESP;
        w_rdata = (r_state == RD_D && !w_tout) ? bus.rdata : '0;
        w_resp  = w_tout ? 2'b11 : (r_state == RD_D ? bus.rresp : bus.bresp);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_resp    <= '0;
            r_tout    <= 1'b0;
            r_cnt     <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && bus.req_valid) begin
                r_addr    <= bus.req_addr[ADDR_W-1:0];
                r_wdata   <= bus.req_wdata;
                r_wstrb   <= bus.req_wstrb;
                r_cnt     <= '0;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else if (w_busy && r_cnt != CW'(TIMEOUT)) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (r_state == WR_AW && bus.awready) r_aw_done <= 1'b1;
            if (r_state == WR_AW && bus.wready) r_w_done <= 1'b1;
            if (w_cap) begin
                r_rdata <= w_rdata;
                r_resp  <= w_resp;
                r_tout  <= w_tout;
            end
        end
    end

    assign bus.req_ready   = r_state == IDLE;
    assign bus.rsp_valid   = r_state == RESP;
    assign bus.rsp_rdata   = r_rdata;
    assign bus.rsp_resp    = r_resp;
    assign bus.rsp_timeout = r_tout && r_state == RESP;
    assign bus.araddr      = r_addr;
    assign bus.arvalid     = r_state == RD_A;
    assign bus.rready      = r_state == RD_D;
    assign bus.awaddr      = r_addr;
    assign bus.awvalid     = r_state == WR_AW && !r_aw_done;
    assign bus.wdata       = r_wdata;
    assign bus.wstrb       = r_wstrb;
    assign bus.wvalid      = r_state == WR_AW && !r_w_done;
    assign bus.bready      = r_state == WR_B;
endmodule
